// File: rtl/alu_pkg.sv
// Shared opcode encoding and width constants for the ALU pipeline.
package alu_pkg;

    localparam int ALU_OP_W  = 4;
    localparam int ALU_WIDTH = 32;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'd0;
    localparam alu_op_t ALU_SUB  = 4'd1;
    localparam alu_op_t ALU_AND  = 4'd2;
    localparam alu_op_t ALU_OR   = 4'd3;
    localparam alu_op_t ALU_XOR  = 4'd4;
    localparam alu_op_t ALU_NOR  = 4'd5;
    localparam alu_op_t ALU_SLT  = 4'd6;
    localparam alu_op_t ALU_SLTU = 4'd7;
    localparam alu_op_t ALU_SLL  = 4'd8;
    localparam alu_op_t ALU_SRL  = 4'd9;
    localparam alu_op_t ALU_SRA  = 4'd10;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: add, subtract, compares, bitwise logic and shifts.
// Reserved opcodes (11-15) yield a zero result with no overflow.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [ALU_OP_W-1:0] i_op,
    input  logic [WIDTH-1:0]    i_a,
    input  logic [WIDTH-1:0]    i_b,
    output logic [WIDTH-1:0]    o_q,
    output logic                o_of
);

    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0] w_sum;
    logic             w_add_of;
    logic [WIDTH:0]   w_diff_c;
    logic [WIDTH-1:0] w_diff;
    logic             w_sub_of;
    logic             w_slt;
    logic             w_sltu;
    logic [SH_W-1:0]  w_shamt;

    assign w_sum    = i_a + i_b;
    assign w_add_of = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

    // Subtract as A + ~B + 1; the top bit is the carry, i.e. "no borrow".
    assign w_diff_c = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_diff   = w_diff_c[WIDTH-1:0];
    assign w_sub_of = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
    assign w_slt    = w_diff[WIDTH-1] ^ w_sub_of;
    assign w_sltu   = ~w_diff_c[WIDTH];

    assign w_shamt  = i_b[SH_W-1:0];

    always_comb begin
        o_q  = '0;
        o_of = 1'b0;
        case (i_op)
            ALU_ADD:  begin o_q = w_sum;  o_of = w_add_of; end
            ALU_SUB:  begin o_q = w_diff; o_of = w_sub_of; end
            ALU_AND:  o_q = i_a & i_b;
            ALU_OR:   o_q = i_a | i_b;
            ALU_XOR:  o_q = i_a ^ i_b;
            ALU_NOR:  o_q = ~(i_a | i_b);
            ALU_SLT:  begin o_q = {{(WIDTH-1){1'b0}}, w_slt};  o_of = w_sub_of; end
            ALU_SLTU: begin o_q = {{(WIDTH-1){1'b0}}, w_sltu}; o_of = w_sub_of; end
            ALU_SLL:  o_q = i_a << w_shamt;
            ALU_SRL:  o_q = i_a >> w_shamt;
            ALU_SRA:  o_q = $signed(i_a) >>> w_shamt;
            default:  begin o_q = '0; o_of = 1'b0; end
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage registered ALU with valid/ready handshake on both sides.
// Optional out_zero flag is enabled by defining ALU_PIPE_FLAGS_EN.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_q,
`ifdef ALU_PIPE_FLAGS_EN
    output logic                out_zero,
`endif
    output logic                out_of
);

    logic                r_s1_valid;
    logic [ALU_OP_W-1:0] r_s1_op;
    logic [WIDTH-1:0]    r_s1_a;
    logic [WIDTH-1:0]    r_s1_b;
    logic                r_s2_valid;
    logic [WIDTH-1:0]    r_s2_q;
    logic                r_s2_of;

    logic                w_advance;
    logic                w_in_fire;
    logic [WIDTH-1:0]    w_q;
    logic                w_of;

    assign w_advance = r_s1_valid && (!r_s2_valid || out_ready);
    // Held low during reset so nothing is offered as accepted while the pipe is cleared.
    assign in_ready  = !rst && (!r_s1_valid || w_advance);
    assign w_in_fire = in_valid && in_ready;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_op (r_s1_op),
        .i_a  (r_s1_a),
        .i_b  (r_s1_b),
        .o_q  (w_q),
        .o_of (w_of)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= in_op;
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
        end else if (w_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_q     <= '0;
            r_s2_of    <= 1'b0;
        end else if (w_advance) begin
            r_s2_valid <= 1'b1;
            r_s2_q     <= w_q;
            r_s2_of    <= w_of;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

`ifdef ALU_PIPE_FLAGS_EN
    logic r_s2_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_zero <= 1'b0;
        end else if (w_advance) begin
            r_s2_zero <= (w_q == '0);
        end
    end

    assign out_zero = r_s2_zero;
`endif

    assign out_valid = r_s2_valid;
    assign out_q     = r_s2_q;
    assign out_of    = r_s2_of;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: vector table through a scoreboard plus
// hand-written reset, latency, backpressure and mid-stream reset sequences.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_q;
    logic        out_of;
`ifdef ALU_PIPE_FLAGS_EN
    logic        out_zero;
`endif

    alu_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
`ifdef ALU_PIPE_FLAGS_EN
        .out_zero  (out_zero),
`endif
        .out_of    (out_of)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        of;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic        of;
        int          id;
    } exp_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];
    exp_t sb [$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          out_count = 0;
    logic [31:0] cur_q;
    logic        cur_of;
    int          cur_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic of, input int id);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        cur_q    = q;
        cur_of   = of;
        cur_id   = id;
    endtask

    // One clock: sample outputs and handshakes on the falling edge, then
    // return 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            out_count++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got q=%h with no pending op, expected none", out_q);
            end else begin
                e = sb.pop_front();
                chk($sformatf("op%0d q", e.id), out_q, e.q);
                chk($sformatf("op%0d of", e.id), {31'b0, out_of}, {31'b0, e.of});
`ifdef ALU_PIPE_FLAGS_EN
                chk($sformatf("op%0d zero", e.id), {31'b0, out_zero}, {31'b0, (e.q == 32'h0)});
`endif
            end
        end
        if (in_valid && in_ready) sb.push_back('{q: cur_q, of: cur_of, id: cur_id});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          base;
        int          sent;
        logic        acc;
        logic [31:0] hold_q;
        logic [31:0] ba;

        vecs[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
        vecs[1]  = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
        vecs[2]  = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        vecs[3]  = '{ALU_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[4]  = '{ALU_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[5]  = '{ALU_SLTU, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
        vecs[6]  = '{ALU_SLT,  32'h80000000, 32'h00000000, 32'h00000001, 1'b0};
        vecs[7]  = '{ALU_SRA,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{ALU_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0};
        vecs[9]  = '{4'd15,    32'h00001234, 32'h00005678, 32'h00000000, 1'b0};
        vecs[10] = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        vecs[11] = '{ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
        vecs[12] = '{ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
        vecs[13] = '{ALU_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0};
        vecs[14] = '{ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0};
        vecs[15] = '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
        vecs[16] = '{ALU_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1};
        vecs[17] = '{ALU_SLTU, 32'h7FFFFFFF, 32'h80000000, 32'h00000001, 1'b1};
        vecs[18] = '{4'd11,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};

        // Reset held with a request pending
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 999);
        @(negedge clk);
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst out_q", out_q, 32'd0);
        chk("rst out_of", {31'b0, out_of}, 32'd0);
        chk("rst in_ready", {31'b0, in_ready}, 32'd0);
`ifdef ALU_PIPE_FLAGS_EN
        chk("rst out_zero", {31'b0, out_zero}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post-rst in_ready", {31'b0, in_ready}, 32'd1);
        chk("post-rst out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // First-op latency: accept at edge N, result after edge N+1
        drive(ALU_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 100);
        tick();
        in_valid = 1'b0;
        chk("lat after N out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("lat after N+1 out_valid", {31'b0, out_valid}, 32'd1);
        chk("lat after N+1 out_q", out_q, 32'd30);
        tick();
        chk("lat sb drained", sb.size(), 32'd0);

        // Vector table streamed back-to-back
        base = out_count;
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].of, i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("table throughput count", out_count - base, NVEC);
        tick();
        chk("table sb drained", sb.size(), 32'd0);

        // Backpressure: 4 ADDs, consumer stalled for the first 3 cycles
        base = out_count;
        sent = 0;
        hold_q = '0;
        for (int c = 0; c < 12; c++) begin
            out_ready = (c >= 3);
            if (sent < 4) begin
                ba = 32'h100 * (sent + 1);
                drive(ALU_ADD, ba, sent + 3, ba + sent + 3, 1'b0, 200 + sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 2) begin
                chk("bp full in_ready", {31'b0, in_ready}, 32'd0);
                chk("bp stall out_valid", {31'b0, out_valid}, 32'd1);
                hold_q = out_q;
                chk("bp stall out_q", hold_q, 32'h00000103);
            end
            if (c == 3) chk("bp out_q stable", out_q, hold_q);
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
        end
        chk("bp accepted", sent, 32'd4);
        chk("bp results count", out_count - base, 32'd4);
        chk("bp sb drained", sb.size(), 32'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 300);
        tick();
        drive(ALU_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 301);
        tick();
        in_valid = 1'b0;
        #1;
        chk("mid full in_ready", {31'b0, in_ready}, 32'd0);
        chk("mid full out_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid rst out_q", out_q, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        base      = out_count;
        drive(ALU_ADD, 32'd7, 32'd8, 32'd15, 1'b0, 302);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("mid only one result", out_count - base, 32'd1);
        chk("mid sb drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
